// File: rtl/nubus_pkg.sv
// NuBus master-side shared types and constants.
// State encoding plus RQST*/START*/ACK* line polarity.
package nubus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LOST,
    WAIT_BUS,
    OWN
  } state_t;

  localparam int ARB_CYCLES_DEF = 2;

  localparam logic LINE_ACT = 1'b0;
  localparam logic LINE_REL = 1'b1;

endpackage

// File: rtl/nubus_busy_tracker.sv
// Tracks whether a NuBus transaction is in flight.
// START-only opens it, ACK-only closes it, attention holds.
module nubus_busy_tracker
  import nubus_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic nub_startni,
  input  logic nub_ackni,
  output logic busy
);

  logic start_a;
  logic ack_a;

  assign start_a = (nub_startni == LINE_ACT);
  assign ack_a   = (nub_ackni == LINE_ACT);

  // busy flag follows START-only / ACK-only clocks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
    end else if (start_a && !ack_a) begin
      busy <= 1'b1;
    end else if (ack_a && !start_a) begin
      busy <= 1'b0;
    end
  end

endmodule

// File: rtl/nubus_master_request.sv
// NuBus master request/ownership controller.
// Arbitration timing, bus-free wait, fairness, watchdog.
module nubus_master_request
  import nubus_pkg::*;
#(
  parameter int ARB_CYCLES = ARB_CYCLES_DEF,
  parameter int TMO_CYCLES = 255,
  parameter int TMO_W      = 8
) (
  input  logic nub_clk,
  input  logic nub_reset,
  input  logic req_i,
  input  logic lock_i,
  input  logic done_i,
  input  logic grant_i,
  input  logic nub_rqstni,
  input  logic nub_startni,
  input  logic nub_ackni,
  output logic arbcy_o,
  output logic nub_rqst_oe,
  output logic start_o,
  output logic owner_o,
  output logic tmo_o
);

  localparam int ARB_W =
    (ARB_CYCLES > 1) ? $clog2(ARB_CYCLES) : 1;
  localparam logic [ARB_W-1:0] ARB_LAST =
    ARB_W'(ARB_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'(TMO_CYCLES - 1);

  state_t           state;
  logic [ARB_W-1:0] arb_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             seen_start;
  logic             fair_block;
  logic             busy;
  logic             start_only;
  logic             ack_only;
  logic             rqst_free;

  assign start_only = (nub_startni == LINE_ACT) &&
                      (nub_ackni == LINE_REL);
  assign ack_only   = (nub_ackni == LINE_ACT) &&
                      (nub_startni == LINE_REL);
  assign rqst_free  = (nub_rqstni == LINE_REL);

  nubus_busy_tracker u_busy (
    .clk         (nub_clk),
    .rst         (nub_reset),
    .nub_startni (nub_startni),
    .nub_ackni   (nub_ackni),
    .busy        (busy)
  );

  // request FSM with registered outputs and fairness latch
  always_ff @(posedge nub_clk or posedge nub_reset) begin
    if (nub_reset) begin
      state       <= IDLE;
      arb_cnt     <= '0;
      tmo_cnt     <= '0;
      seen_start  <= 1'b0;
      fair_block  <= 1'b0;
      arbcy_o     <= 1'b0;
      nub_rqst_oe <= 1'b0;
      start_o     <= 1'b0;
      owner_o     <= 1'b0;
      tmo_o       <= 1'b0;
    end else begin
      start_o <= 1'b0;
      tmo_o   <= 1'b0;
      if (rqst_free) fair_block <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_i && (!fair_block || rqst_free)) begin
            state       <= ARB;
            arb_cnt     <= '0;
            arbcy_o     <= 1'b1;
            nub_rqst_oe <= 1'b1;
          end
        end
        ARB: begin
          if (!req_i) begin
            state       <= IDLE;
            arbcy_o     <= 1'b0;
            nub_rqst_oe <= 1'b0;
          end else if (arb_cnt == ARB_LAST) begin
            if (grant_i) begin
              state <= WAIT_BUS;
            end else begin
              state      <= LOST;
              arbcy_o    <= 1'b0;
              seen_start <= 1'b0;
            end
          end else begin
            arb_cnt <= arb_cnt + 1'b1;
          end
        end
        LOST: begin
          if (!req_i) begin
            state       <= IDLE;
            nub_rqst_oe <= 1'b0;
          end else if (!seen_start) begin
            if (start_only) seen_start <= 1'b1;
          end else if (ack_only) begin
            state   <= ARB;
            arb_cnt <= '0;
            arbcy_o <= 1'b1;
          end
        end
        WAIT_BUS: begin
          if (!req_i) begin
            state       <= IDLE;
            arbcy_o     <= 1'b0;
            nub_rqst_oe <= 1'b0;
          end else if (!busy) begin
            state       <= OWN;
            start_o     <= 1'b1;
            owner_o     <= 1'b1;
            arbcy_o     <= 1'b0;
            nub_rqst_oe <= lock_i;
            tmo_cnt     <= '0;
          end
        end
        OWN: begin
          nub_rqst_oe <= lock_i;
          if (done_i && lock_i && req_i) begin
            start_o <= 1'b1;
            tmo_cnt <= '0;
          end else if (done_i || tmo_cnt == TMO_LAST) begin
            state       <= IDLE;
            owner_o     <= 1'b0;
            nub_rqst_oe <= 1'b0;
            fair_block  <= 1'b1;
            tmo_o       <= !done_i;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          arbcy_o     <= 1'b0;
          nub_rqst_oe <= 1'b0;
          owner_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nubus_master_request.sv
// Bench for nubus_master_request: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_nubus_master_request;

  localparam int ARB_C = 2;
  localparam int TMO_C = 4;

  logic nub_clk = 1'b0;
  logic nub_reset = 1'b1;
  logic req_i = 1'b0;
  logic lock_i = 1'b0;
  logic done_i = 1'b0;
  logic grant_i = 1'b1;
  logic nub_rqstni = 1'b1;
  logic nub_startni = 1'b1;
  logic nub_ackni = 1'b1;
  logic arbcy_o, nub_rqst_oe, start_o, owner_o, tmo_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 nub_clk = ~nub_clk;

  nubus_master_request #(
    .ARB_CYCLES (ARB_C),
    .TMO_CYCLES (TMO_C),
    .TMO_W      (3)
  ) dut (
    .nub_clk     (nub_clk),
    .nub_reset   (nub_reset),
    .req_i       (req_i),
    .lock_i      (lock_i),
    .done_i      (done_i),
    .grant_i     (grant_i),
    .nub_rqstni  (nub_rqstni),
    .nub_startni (nub_startni),
    .nub_ackni   (nub_ackni),
    .arbcy_o     (arbcy_o),
    .nub_rqst_oe (nub_rqst_oe),
    .start_o     (start_o),
    .owner_o     (owner_o),
    .tmo_o       (tmo_o)
  );

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] outs();
    return {3'b0, arbcy_o, nub_rqst_oe, start_o,
            owner_o, tmo_o};
  endfunction

  // Model: phase 0 idle,1 contest,2 lost,3 wait free,4 own
  int mph = 0;
  int mcnt = 0;
  bit mseen = 0, mbusy = 0, mfair = 0, mlock = 0;
  bit e_start = 0, e_tmo = 0;
  bit e_arb, e_oe, e_own;

  always @(posedge nub_clk) begin
    bit st_only, ack_only, nb, nf;
    e_start = 0;
    e_tmo = 0;
    if (nub_reset) begin
      mph = 0; mcnt = 0; mseen = 0;
      mbusy = 0; mfair = 0; mlock = 0;
    end else begin
      st_only  = !nub_startni && nub_ackni;
      ack_only = nub_startni && !nub_ackni;
      nb = st_only ? 1'b1 : (ack_only ? 1'b0 : mbusy);
      nf = nub_rqstni ? 1'b0 : mfair;
      case (mph)
        0: if (req_i && (!mfair || nub_rqstni)) begin
             mph = 1; mcnt = 0;
           end
        1: if (!req_i) mph = 0;
           else if (mcnt == ARB_C - 1) begin
             mph = grant_i ? 3 : 2;
             mseen = 0;
           end else mcnt++;
        2: if (!req_i) mph = 0;
           else if (!mseen) mseen = st_only;
           else if (ack_only) begin mph = 1; mcnt = 0; end
        3: if (!req_i) mph = 0;
           else if (!mbusy) begin
             mph = 4; e_start = 1; mcnt = 0; mlock = lock_i;
           end
        4: if (done_i && lock_i && req_i) begin
             e_start = 1; mcnt = 0; mlock = lock_i;
           end else if (done_i || mcnt == TMO_C - 1) begin
             mph = 0; nf = 1; e_tmo = !done_i;
           end else begin
             mcnt++; mlock = lock_i;
           end
        default: mph = 0;
      endcase
      mbusy = nb;
      mfair = nf;
    end
    e_arb = (mph == 1) || (mph == 3);
    e_own = (mph == 4);
    e_oe  = (mph >= 1 && mph <= 3) || (mph == 4 && mlock);
    #1;
    chk("m_arbcy", {7'b0, arbcy_o}, {7'b0, e_arb});
    chk("m_rqst_oe", {7'b0, nub_rqst_oe}, {7'b0, e_oe});
    chk("m_start", {7'b0, start_o}, {7'b0, e_start});
    chk("m_owner", {7'b0, owner_o}, {7'b0, e_own});
    chk("m_tmo", {7'b0, tmo_o}, {7'b0, e_tmo});
    chk("m_excl", {7'b0, owner_o & arbcy_o}, 8'h0);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge nub_clk);
  endtask

  task automatic wait_owner();
    for (int i = 0; i < 20; i++) begin
      if (owner_o) break;
      cyc(1);
    end
    chk("wait_owner", {7'b0, owner_o}, 8'h1);
  endtask

  task automatic pulse_reset(input string nm);
    #2 nub_reset = 1'b1;
    #1 chk(nm, outs(), 8'h0);
    req_i = 1'b0;
    cyc(1);
    nub_reset = 1'b0;
    cyc(2);
    chk({nm, "_idle"}, outs(), 8'h0);
  endtask

  initial begin
    #3 chk("reset_outs", outs(), 8'h0);
    cyc(2);
    nub_reset = 1'b0;
    cyc(1);

    // uncontested on an idle bus
    req_i = 1'b1;
    cyc(1);
    chk("u_arbcy_c1", {7'b0, arbcy_o}, 8'h1);
    cyc(1);
    chk("u_arbcy_c2", {7'b0, arbcy_o}, 8'h1);
    cyc(1);
    chk("u_nostart_c3", {7'b0, start_o}, 8'h0);
    cyc(1);
    chk("u_start_c4", {7'b0, start_o}, 8'h1);
    chk("u_owner_c4", {7'b0, owner_o}, 8'h1);
    chk("u_oe_c4", {7'b0, nub_rqst_oe}, 8'h0);

    // fairness hold-off after release
    cyc(1);
    done_i = 1'b1;
    nub_rqstni = 1'b0;
    cyc(1);
    done_i = 1'b0;
    chk("f_released", {7'b0, owner_o}, 8'h0);
    cyc(10);
    chk("f_blocked", {7'b0, arbcy_o}, 8'h0);
    nub_rqstni = 1'b1;
    cyc(1);
    chk("f_rearb", {7'b0, arbcy_o}, 8'h1);

    // watchdog fires 4 cycles into ownership
    wait_owner();
    cyc(3);
    chk("w_own_e3", {7'b0, owner_o}, 8'h1);
    chk("w_notmo_e3", {7'b0, tmo_o}, 8'h0);
    cyc(1);
    chk("w_tmo_e4", {7'b0, tmo_o}, 8'h1);
    chk("w_free_e4", {7'b0, owner_o}, 8'h0);

    // done on the timeout clock suppresses tmo
    wait_owner();
    cyc(3);
    done_i = 1'b1;
    cyc(1);
    done_i = 1'b0;
    chk("wd_notmo", {7'b0, tmo_o}, 8'h0);
    chk("wd_free", {7'b0, owner_o}, 8'h0);

    // lose, watch winner's START then ACK, recontest
    req_i = 1'b0;
    cyc(2);
    grant_i = 1'b0;
    req_i = 1'b1;
    cyc(3);
    chk("l_arbcy", {7'b0, arbcy_o}, 8'h0);
    chk("l_oe", {7'b0, nub_rqst_oe}, 8'h1);
    cyc(3);
    nub_startni = 1'b0;
    cyc(1);
    nub_startni = 1'b1;
    cyc(4);
    chk("l_wait_ack", {7'b0, arbcy_o}, 8'h0);
    nub_ackni = 1'b0;
    cyc(1);
    nub_ackni = 1'b1;
    chk("l_rearb", {7'b0, arbcy_o}, 8'h1);
    grant_i = 1'b1;
    cyc(3);
    chk("l_start", {7'b0, start_o}, 8'h1);
    done_i = 1'b1;
    cyc(1);
    done_i = 1'b0;

    // win on a busy bus, attention cycle does not free it
    nub_startni = 1'b0;
    cyc(1);
    nub_startni = 1'b1;
    cyc(5);
    chk("b_held", {7'b0, start_o | owner_o}, 8'h0);
    chk("b_arbcy", {7'b0, arbcy_o}, 8'h1);
    nub_startni = 1'b0;
    nub_ackni = 1'b0;
    cyc(1);
    nub_startni = 1'b1;
    nub_ackni = 1'b1;
    cyc(2);
    chk("b_attn", {7'b0, start_o | owner_o}, 8'h0);
    nub_ackni = 1'b0;
    cyc(1);
    nub_ackni = 1'b1;
    chk("b_ack_c1", {7'b0, start_o}, 8'h0);
    cyc(1);
    chk("b_start", {7'b0, start_o}, 8'h1);

    // asynchronous reset mid-ownership
    pulse_reset("r_own");

    // asynchronous reset mid-wait for a busy bus
    nub_startni = 1'b0;
    cyc(1);
    nub_startni = 1'b1;
    req_i = 1'b1;
    cyc(4);
    chk("r_in_wait", {7'b0, arbcy_o & ~owner_o}, 8'h1);
    pulse_reset("r_wait");

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      req_i       = ($urandom_range(9) < 8);
      lock_i      = ($urandom_range(9) < 3);
      done_i      = ($urandom_range(9) == 0);
      grant_i     = $urandom_range(1);
      nub_rqstni  = $urandom_range(1);
      nub_startni = ($urandom_range(4) != 0);
      nub_ackni   = ($urandom_range(4) != 0);
      nub_reset   = ($urandom_range(299) == 0);
      cyc(1);
    end
    nub_reset = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
